// File: rtl/dmem_io.sv
// Data memory plus memory-mapped I/O behind the core's Memory stage:
// word RAM, GPIO out/in, a down-counting timer with IRQ and a cycle counter.
module dmem_io #(
   parameter int unsigned RAM_ADDR_BITS = 6,
   parameter logic [15:0] IO_BASE       = 16'hFFFF,
   parameter int unsigned GPIO_W        = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemWriteM,
   input  logic [31:0]       ALUOutM,
   input  logic [31:0]       WriteDataM,
   output logic [31:0]       ReadDataM,
   input  logic [GPIO_W-1:0] GpioIn,
   output logic [GPIO_W-1:0] GpioOut,
   output logic              TimerIrq
);

   localparam int unsigned RAM_WORDS = 1 << RAM_ADDR_BITS;

   // I/O register word offsets (ALUOutM[7:2])
   localparam logic [5:0] OFF_GPIO_OUT = 6'h00;
   localparam logic [5:0] OFF_GPIO_IN  = 6'h01;
   localparam logic [5:0] OFF_CTRL     = 6'h02;
   localparam logic [5:0] OFF_LOAD     = 6'h03;
   localparam logic [5:0] OFF_COUNT    = 6'h04;
   localparam logic [5:0] OFF_CYCLE    = 6'h05;

   logic [31:0]              mem [RAM_WORDS];
   logic                     ioSel;
   logic                     ramSel;
   logic [5:0]               ioOff;
   logic [RAM_ADDR_BITS-1:0] ramIdx;
   logic                     ramWr;
   logic                     gpioWr;
   logic                     ctrlWr;
   logic                     loadWr;

   logic [GPIO_W-1:0]        syncMeta;
   logic [GPIO_W-1:0]        syncOut;
   logic                     ctrlEn;
   logic                     ctrlAuto;
   logic                     ctrlStatus;
   logic                     ctrlIrqEn;
   logic [31:0]              timerLoad;
   logic [31:0]              timerCount;
   logic [31:0]              cycleCnt;

   logic                     expire;
   logic                     enNext;
   logic                     statusNext;
   logic [31:0]              countNext;
   logic                     unusedAddrBits;

   // Address decode; byte-lane bits and I/O bits [15:8] do not participate
   assign ioSel          = (ALUOutM[31:16] == IO_BASE);
   assign ramSel         = ((ALUOutM >> (RAM_ADDR_BITS + 2)) == 32'd0) && !ioSel;
   assign ioOff          = ALUOutM[7:2];
   assign ramIdx         = ALUOutM[RAM_ADDR_BITS+1:2];
   assign unusedAddrBits = ^{ALUOutM[15:8], ALUOutM[1:0]};

   assign ramWr  = MemWriteM && ramSel;
   assign gpioWr = MemWriteM && ioSel && (ioOff == OFF_GPIO_OUT);
   assign ctrlWr = MemWriteM && ioSel && (ioOff == OFF_CTRL);
   assign loadWr = MemWriteM && ioSel && (ioOff == OFF_LOAD);

   // RAM contents survive reset
   always_ff @(posedge clk) begin
      if (ramWr) begin
         mem[ramIdx] <= WriteDataM;
      end
   end

   // Timer next state: a LOAD write pre-empts counting and expiry; a CTRL
   // write still sets EN but cannot clear a STATUS that expires this edge.
   always_comb begin
      expire    = 1'b0;
      enNext    = ctrlEn;
      countNext = timerCount;
      if (loadWr) begin
         countNext = WriteDataM;
      end else if (ctrlEn) begin
         if (timerCount != 32'd0) begin
            countNext = timerCount - 32'd1;
         end else begin
            expire = 1'b1;
            if (ctrlAuto) begin
               countNext = timerLoad;
            end else begin
               enNext = 1'b0;
            end
         end
      end
      if (ctrlWr) begin
         enNext = WriteDataM[0];
      end
      statusNext = (ctrlStatus && !(ctrlWr && WriteDataM[2])) || expire;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         GpioOut    <= '0;
         syncMeta   <= '0;
         syncOut    <= '0;
         ctrlEn     <= 1'b0;
         ctrlAuto   <= 1'b0;
         ctrlStatus <= 1'b0;
         ctrlIrqEn  <= 1'b0;
         timerLoad  <= 32'd0;
         timerCount <= 32'd0;
         cycleCnt   <= 32'd0;
      end else begin
         syncMeta   <= GpioIn;
         syncOut    <= syncMeta;
         cycleCnt   <= cycleCnt + 32'd1;
         ctrlEn     <= enNext;
         ctrlStatus <= statusNext;
         timerCount <= countNext;
         if (gpioWr) begin
            GpioOut <= WriteDataM[GPIO_W-1:0];
         end
         if (ctrlWr) begin
            ctrlAuto  <= WriteDataM[1];
            ctrlIrqEn <= WriteDataM[3];
         end
         if (loadWr) begin
            timerLoad <= WriteDataM;
         end
      end
   end

   assign TimerIrq = ctrlStatus && ctrlIrqEn;

   // Zero-latency read mux; unmapped space and unused offsets read 0
   always_comb begin
      ReadDataM = 32'd0;
      if (ramSel) begin
         ReadDataM = mem[ramIdx];
      end else if (ioSel) begin
         case (ioOff)
            OFF_GPIO_OUT: ReadDataM = 32'(GpioOut);
            OFF_GPIO_IN:  ReadDataM = 32'(syncOut);
            OFF_CTRL:     ReadDataM = {28'd0, ctrlIrqEn, ctrlStatus, ctrlAuto, ctrlEn};
            OFF_LOAD:     ReadDataM = timerLoad;
            OFF_COUNT:    ReadDataM = timerCount;
            OFF_CYCLE:    ReadDataM = cycleCnt;
            default:      ReadDataM = 32'd0;
         endcase
      end
   end

endmodule
